// File: rtl/life_pkg.sv
// Shared constants, the neighbour-count type and the birth/survival rule
// used by the Game of Life row engine.
package life_pkg;

    localparam int NCOUNT_W  = 4;
    localparam int BIRTH_N   = 3;
    localparam int SURVIVE_N = 2;

    typedef logic [NCOUNT_W-1:0] ncount_t;

    function automatic logic life_rule(input ncount_t n, input logic alive);
        return (n == ncount_t'(BIRTH_N)) || (alive && (n == ncount_t'(SURVIVE_N)));
    endfunction

endpackage

// File: rtl/neighbor_sum.sv
// Adder-tree neighbour counter: eight single-bit neighbours reduced to a
// 4-bit count (0..8) using half/full adder cells.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module neighbor_sum
    import life_pkg::*;
(
    input  logic [7:0] nb_i,
    output ncount_t    count_o
);
    logic s0, s1, s2, c0, c1, c2, c3;
    logic t0, t1, t2;
    logic b0, b1, b2, b3;

    // Level 1 reduces eight weight-1 bits to three sums and three weight-2 carries.
    full_adder u_fa0 (.a_i(nb_i[0]), .b_i(nb_i[1]), .c_i(nb_i[2]), .s_o(s0), .c_o(c0));
    full_adder u_fa1 (.a_i(nb_i[3]), .b_i(nb_i[4]), .c_i(nb_i[5]), .s_o(s1), .c_o(c1));
    half_adder u_ha0 (.a_i(nb_i[6]), .b_i(nb_i[7]), .s_o(s2), .c_o(c2));

    full_adder u_fa2 (.a_i(s0), .b_i(s1), .c_i(s2), .s_o(b0), .c_o(c3));
    full_adder u_fa3 (.a_i(c0), .b_i(c1), .c_i(c2), .s_o(t0), .c_o(t1));
    half_adder u_ha1 (.a_i(t0), .b_i(c3), .s_o(b1), .c_o(t2));
    half_adder u_ha2 (.a_i(t1), .b_i(t2), .s_o(b2), .c_o(b3));

    assign count_o = {b3, b2, b1, b0};
endmodule

// File: rtl/life_row_engine.sv
// Two-stage Game of Life row engine: stage 1 registers per-cell neighbour
// counts, stage 2 applies the rule and the population count.
module life_row_engine
    import life_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WRAP  = 1,
    parameter int POP_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_above,
    input  logic [WIDTH-1:0] row_cur,
    input  logic [WIDTH-1:0] row_below,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] row_next,
    output logic [POP_W-1:0] row_pop,
    output logic [15:0]      rows_done
);
    logic             adv;
    ncount_t          cnt_d [WIDTH];
    ncount_t          cnt_q [WIDTH];
    logic [WIDTH-1:0] cur_q;
    logic             v1_q;
    logic [WIDTH-1:0] next_row_d;
    logic [POP_W-1:0] pop_d;
    logic [WIDTH-1:0] row_next_q;
    logic [POP_W-1:0] pop_q;
    logic             v2_q;
    logic [15:0]      done_q;

    assign adv      = !v2_q || out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            localparam int   L    = (gi == 0) ? WIDTH - 1 : gi - 1;
            localparam int   R    = (gi == WIDTH - 1) ? 0 : gi + 1;
            // Without wrap, the column beyond each edge reads as dead.
            localparam logic L_OK = (WRAP != 0) || (gi != 0);
            localparam logic R_OK = (WRAP != 0) || (gi != WIDTH - 1);
            logic [7:0] nb;

            assign nb = {row_above[L] & L_OK, row_above[gi], row_above[R] & R_OK,
                         row_cur[L] & L_OK,   row_cur[R] & R_OK,
                         row_below[L] & L_OK, row_below[gi], row_below[R] & R_OK};

            neighbor_sum u_sum (.nb_i(nb), .count_o(cnt_d[gi]));

            assign next_row_d[gi] = life_rule(cnt_q[gi], cur_q[gi]);
        end
    endgenerate

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_d = pop_d + POP_W'(next_row_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            cur_q      <= '0;
            cnt_q      <= '{default: '0};
            v2_q       <= 1'b0;
            row_next_q <= '0;
            pop_q      <= '0;
            done_q     <= '0;
        end else begin
            if (adv) begin
                v1_q       <= in_valid;
                cur_q      <= row_cur;
                cnt_q      <= cnt_d;
                v2_q       <= v1_q;
                row_next_q <= next_row_d;
                pop_q      <= pop_d;
            end
            if (v2_q && out_ready) begin
                done_q <= done_q + 16'd1;
            end
        end
    end

    assign out_valid = v2_q;
    assign row_next  = row_next_q;
    assign row_pop   = pop_q;
    assign rows_done = done_q;

endmodule

// File: tb/tb_life_row_engine.sv
// Scoreboard bench for life_row_engine: wrapping and non-wrapping 8-cell
// engines share stimulus and are checked against a neighbourhood model.
module tb_life_row_engine;
    localparam int W = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  row_above = '0, row_cur = '0, row_below = '0;
    logic          in_ready_w, in_ready_n, out_valid_w, out_valid_n;
    logic [W-1:0]  row_next_w, row_next_n;
    logic [PW-1:0] row_pop_w, row_pop_n;
    logic [15:0]   rows_done_w, rows_done_n;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] row;
        int           pop;
    } exp_t;

    exp_t        q_w[$];
    exp_t        q_n[$];
    logic [15:0] exp_done = '0;

    always #5 clk = ~clk;

    life_row_engine #(.WIDTH(W), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .row_above(row_above), .row_cur(row_cur), .row_below(row_below),
        .out_valid(out_valid_w), .out_ready(out_ready), .row_next(row_next_w),
        .row_pop(row_pop_w), .rows_done(rows_done_w)
    );

    life_row_engine #(.WIDTH(W), .WRAP(0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .row_above(row_above), .row_cur(row_cur), .row_below(row_below),
        .out_valid(out_valid_n), .out_ready(out_ready), .row_next(row_next_n),
        .row_pop(row_pop_n), .rows_done(rows_done_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: count the live cells of the 3x3 block around each cell.
    function automatic exp_t model(input logic [W-1:0] a, c, b, input bit wrap);
        logic [W-1:0] r [3];
        exp_t e;
        r[0] = a; r[1] = c; r[2] = b;
        e.row = '0;
        e.pop = 0;
        for (int i = 0; i < W; i++) begin
            int n = 0;
            for (int dr = 0; dr < 3; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    int col = i + dc;
                    if (dr == 1 && dc == 0) continue;
                    if (col < 0 || col >= W) begin
                        if (!wrap) continue;
                        col = (col + W) % W;
                    end
                    n += int'(r[dr][col]);
                end
            end
            if (n == 3 || (c[i] && n == 2)) begin
                e.row[i] = 1'b1;
                e.pop++;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q_w.delete();
            q_n.delete();
            exp_done = '0;
        end else begin
            chk("rows_done_w", 32'(rows_done_w), 32'(exp_done));
            chk("rows_done_n", 32'(rows_done_n), 32'(exp_done));
            if (out_valid_n !== out_valid_w) chk("valid_agree", 32'(out_valid_n), 32'(out_valid_w));
            if (out_valid_w && out_ready) begin
                if (q_w.size() == 0 || q_n.size() == 0) begin
                    chk("unexpected_output", 32'(q_w.size()), 32'd1);
                end else begin
                    exp_t ew, en;
                    ew = q_w.pop_front();
                    en = q_n.pop_front();
                    chk("row_next_wrap", 32'(row_next_w), 32'(ew.row));
                    chk("row_pop_wrap", 32'(row_pop_w), 32'(ew.pop));
                    chk("row_next_nowrap", 32'(row_next_n), 32'(en.row));
                    chk("row_pop_nowrap", 32'(row_pop_n), 32'(en.pop));
                end
                exp_done = exp_done + 16'd1;
            end
            if (in_valid && in_ready_w) begin
                q_w.push_back(model(row_above, row_cur, row_below, 1'b1));
                q_n.push_back(model(row_above, row_cur, row_below, 1'b0));
            end
        end
    end

    // Single isolated row on an empty pipeline; checks exact 2-cycle latency.
    task automatic directed(input string nm, input logic [W-1:0] a, c, b,
                            input logic [W-1:0] exp_w, input logic [W-1:0] exp_n);
        @(posedge clk); #1;
        out_ready = 1'b1;
        row_above = a; row_cur = c; row_below = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_early"}, 32'(out_valid_w), 32'd0);
        @(negedge clk);
        chk({nm, "_latency"}, 32'(out_valid_w), 32'd1);
        chk({nm, "_row_w"}, 32'(row_next_w), 32'(exp_w));
        chk({nm, "_row_n"}, 32'(row_next_n), 32'(exp_n));
        chk({nm, "_pop_w"}, 32'(row_pop_w), 32'($countones(exp_w)));
    endtask

    task automatic send(input logic [W-1:0] a, c, b);
        int g = 0;
        row_above = a; row_cur = c; row_below = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_w && g < 50) begin
            g++;
            @(negedge clk);
        end
        chk("accept_wait", 32'(g < 50), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bp_a [4];
        logic [W-1:0] bp_c [4];
        logic [W-1:0] bp_b [4];
        bp_a = '{8'h00, 8'h07, 8'h80, 8'h00};
        bp_c = '{8'h1C, 8'h00, 8'h81, 8'h38};
        bp_b = '{8'h00, 8'h00, 8'h01, 8'h00};

        #2 rst = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid_w), 32'd0);
        chk("reset_row_next", 32'(row_next_w), 32'd0);
        chk("reset_row_pop", 32'(row_pop_w), 32'd0);
        chk("reset_rows_done", 32'(rows_done_w), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("in_ready_after_reset", 32'(in_ready_w), 32'd1);

        directed("blinker", 8'h00, 8'b00011100, 8'h00, 8'b00001000, 8'b00001000);
        directed("birth", 8'b00000111, 8'h00, 8'h00, 8'b00000010, 8'b00000010);
        directed("edge", 8'b10000000, 8'b10000001, 8'b00000001, 8'b10000001, 8'h00);

        repeat (400) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            row_above = 8'($urandom); row_cur = 8'($urandom); row_below = 8'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Fill both stages, then reset asynchronously between clock edges.
        repeat (3) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            row_above = 8'($urandom); row_cur = 8'($urandom); row_below = 8'($urandom);
        end
        @(posedge clk); #1;
        chk("pre_reset_valid", 32'(out_valid_w), 32'd1);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid_w), 32'd0);
        chk("midrst_row_next", 32'(row_next_w), 32'd0);
        chk("midrst_rows_done", 32'(rows_done_w), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("in_ready_after_midrst", 32'(in_ready_w), 32'd1);
        directed("post_reset", 8'h00, 8'b00011100, 8'h00, 8'b00001000, 8'b00001000);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(bp_a[k], bp_c[k], bp_b[k]);
            end
            begin
                int g = 0;
                logic [W-1:0]  cap_row;
                logic [PW-1:0] cap_pop;
                @(negedge clk);
                while (!out_valid_w && g < 20) begin
                    g++;
                    @(negedge clk);
                end
                chk("bp_first_result", 32'(out_valid_w), 32'd1);
                cap_row = row_next_w;
                cap_pop = row_pop_w;
                for (int i = 0; i < 5; i++) begin
                    chk("stall_in_ready", 32'(in_ready_w), 32'd0);
                    chk("stall_out_valid", 32'(out_valid_w), 32'd1);
                    chk("stall_row_next", 32'(row_next_w), 32'(cap_row));
                    chk("stall_row_pop", 32'(row_pop_w), 32'(cap_pop));
                    @(negedge clk);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_rows_done", 32'(rows_done_w), 32'd4);
        chk("bp_queue_empty", 32'(q_w.size()), 32'd0);

        // 65532 more handshakes bring the counter to 65536, i.e. back to zero.
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (65532) begin
            in_valid = 1'b1;
            row_above = 8'($urandom); row_cur = 8'($urandom); row_below = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wrap_rows_done", 32'(rows_done_w), 32'd0);
        chk("wrap_queue_empty", 32'(q_w.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/life_row_engine.md
# life_row_engine

Pipelined Game of Life rule unit. It computes the next generation of one WIDTH-cell row from three input rows (above, current, below) and returns the new row with its population count. It generalises the adder primitives into a parametrised, pipelined neighbour-sum datapath with a valid/ready handshake and selectable edge mode. It sits between the board row buffer and the display/write-back path.

## Interface
- WIDTH, 16: cells per row; min 3.
- WRAP, 1: 1 = toroidal edges (column indices mod WIDTH); 0 = out-of-range neighbours read as dead.
- POP_W, $clog2(WIDTH+1): width of the population output.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input rows valid.
- in_ready  out  1  engine accepts input this cycle.
- row_above  in  WIDTH  row r-1; bit i = column i.
- row_cur  in  WIDTH  row r.
- row_below  in  WIDTH  row r+1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- row_next  out  WIDTH  next-generation row r.
- row_pop  out  POP_W  number of 1s in row_next.
- rows_done  out  16  count of completed output handshakes; wraps from 0xFFFF to 0.

## Operation
- Neighbours of cell i: columns i-1, i+1 of row_cur; columns i-1, i, i+1 of row_above and row_below. Edge columns follow WRAP.
- Stage 1 registers a 4-bit neighbour count per cell (range 0..8) and a copy of row_cur.
- Stage 2 applies the rule next = (n == 3) | (cur & n == 2), registers row_next, and registers row_pop as the popcount of the new row.
- Global advance: adv = !out_valid | out_ready. Both stages load only when adv = 1. in_ready = adv.
- Input is accepted on in_valid & in_ready. The stage-1 valid bit loads in_valid & adv. The stage-2 valid bit (out_valid) loads the stage-1 valid bit on adv.
- A bubble in stage 1 propagates as out_valid = 0. It never blocks the pipeline, because adv = 1 whenever out_valid = 0.
- rows_done increments on out_valid & out_ready.
- Arithmetic: counts are zero-extended and never saturate (max 8 fits in 4 bits). row_pop max is WIDTH, which fits POP_W.

## Timing
- Latency: input accepted in cycle t -> out_valid and data presented in cycle t+2 when there is no backpressure.
- Throughput: 1 row/cycle while out_ready = 1.
- Stall: while out_valid & !out_ready, row_next, row_pop and out_valid hold stable, and in_ready = 0. Input data is ignored while in_ready = 0.
- An accept and a new output can occur in the same cycle as out_ready = 1. This is the simultaneous drain/fill case and has no bubble.
- Reset (asynchronous, at any time including mid-pipeline): both valid bits clear, in-flight rows are dropped, row_next = 0, row_pop = 0, rows_done = 0, out_valid = 0.
- After rst deasserts, in_ready = 1 in the first cycle.

## Structure
- Package life_pkg:
  - NCOUNT_W = 4
  - BIRTH_N = 3
  - SURVIVE_N = 2
  - neighbour-count typedef logic [NCOUNT_W-1:0]
- Sub-module neighbor_sum: 8 single-bit inputs -> 4-bit count, built as an adder tree from the existing half_adder and full_adder cells. It is instantiated WIDTH times by a generate loop.
- Popcount is an inline tree in the stage-2 logic.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Blinker, WRAP=1: above=0x00, cur=0b00011100, below=0x00 -> row_next=0b00001000, row_pop=1, two cycles after accept.
- Birth: above=0b00000111, cur=0, below=0 -> row_next=0b00000010, row_pop=1.
- Edge mode: above=0b10000000, cur=0b10000001, below=0b00000001.
  - WRAP=1 -> row_next=0b10000001, row_pop=2.
  - WRAP=0 -> row_next=0x00, row_pop=0.
- Backpressure: stream 4 distinct rows, hold out_ready=0 for 5 cycles after the first result. Required:
  - in_ready=0 for the whole stall.
  - Outputs stay stable during the stall.
  - All 4 results emerge in order with no loss or duplication.
  - rows_done=4.
- Reset mid-operation: assert rst with both stages valid -> out_valid=0, row_next=0, rows_done=0 immediately. After release, the next input produces a correct result at latency 2.
- Counter wrap: force 65536 handshakes -> rows_done returns to 0.
